// File: rtl/tang20k_soc_pkg.sv
// Shared types and constants for the Tang20K SoC data-memory AHB fabric.
// Data-phase select, default-slave states, base addresses and AHB encodings.
package tang20k_soc_pkg;

    localparam logic [15:0] RAM_BASE_DEF  = 16'h0000;
    localparam logic [15:0] UART_BASE_DEF = 16'hFFDF;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DP_IDLE = 2'd0,
        DP_RAM  = 2'd1,
        DP_UART = 2'd2,
        DP_DEF  = 2'd3
    } dsel_t;

    typedef enum logic [1:0] {
        DS_OK   = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

endpackage

// File: rtl/ahb_lite_default_slave.sv
// AHB-Lite default slave: answers unmapped transfers with a two-cycle
// ERROR response (HREADY low then high, HRESP high in both cycles).
module ahb_lite_default_slave
    import tang20k_soc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic unmapped_i,
    output logic hready_o,
    output logic hresp_o
);

    ds_state_t state_q;
    ds_state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DS_OK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hready_o = 1'b1;
        hresp_o  = HRESP_OKAY;
        unique case (state_q)
            DS_OK: begin
                if (load_i && unmapped_i) begin
                    state_d = DS_ERR1;
                end
            end
            DS_ERR1: begin
                hready_o = 1'b0;
                hresp_o  = HRESP_ERROR;
                state_d  = DS_ERR2;
            end
            DS_ERR2: begin
                hresp_o = HRESP_ERROR;
                // a new unmapped transfer accepted here restarts the error pair
                state_d = (load_i && unmapped_i) ? DS_ERR1 : DS_OK;
            end
            default: begin
                state_d = DS_OK;
            end
        endcase
    end

endmodule

// File: rtl/tang20k_dmem_decoder.sv
// SCR1 dmem AHB-Lite 1-to-2 decoder/response mux with built-in default slave.
// Optional error log enabled by defining TANG20K_DMEM_ERRLOG_EN.
module tang20k_dmem_decoder
    import tang20k_soc_pkg::*;
#(
    parameter logic [15:0] RAM_BASE  = RAM_BASE_DEF,
    parameter logic [15:0] UART_BASE = UART_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_haddr,
    input  logic [1:0]  m_htrans,
    input  logic        m_hwrite,
    output logic        m_hready,
    output logic [31:0] m_hrdata,
    output logic        m_hresp,
    output logic        ram_hsel,
    output logic        uart_hsel,
    output logic        s_hready,
    input  logic        ram_hreadyout,
    input  logic        uart_hreadyout,
    input  logic [31:0] ram_hrdata,
    input  logic [31:0] uart_hrdata,
    input  logic        ram_hresp,
    input  logic        uart_hresp,
    input  logic        err_clr,
    output logic        err_valid,
    output logic [31:0] err_addr
);

    dsel_t       dsel_q;
    dsel_t       dsel_d;
    logic [31:0] daddr_q;
    logic        unmapped;
    logic        active;
    logic        ds_load;
    logic        ds_hready;
    logic        ds_hresp;

    assign ram_hsel  = (m_haddr[31:16] == RAM_BASE);
    assign uart_hsel = (m_haddr[31:16] == UART_BASE);
    assign unmapped  = !ram_hsel && !uart_hsel;
    assign active    = (m_htrans == HTRANS_NONSEQ) || (m_htrans == HTRANS_SEQ);
    assign ds_load   = m_hready && active;
    assign s_hready  = m_hready;

    always_comb begin
        dsel_d = DP_IDLE;
        if (active) begin
            if (ram_hsel) begin
                dsel_d = DP_RAM;
            end else if (uart_hsel) begin
                dsel_d = DP_UART;
            end else begin
                dsel_d = DP_DEF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dsel_q  <= DP_IDLE;
            daddr_q <= 32'd0;
        end else if (m_hready) begin
            dsel_q  <= dsel_d;
            daddr_q <= m_haddr;
        end
    end

    ahb_lite_default_slave u_def (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ds_load),
        .unmapped_i (unmapped),
        .hready_o   (ds_hready),
        .hresp_o    (ds_hresp)
    );

    always_comb begin
        m_hready = 1'b1;
        m_hresp  = HRESP_OKAY;
        m_hrdata = 32'd0;
        unique case (dsel_q)
            DP_IDLE: begin
                m_hready = 1'b1;
            end
            DP_RAM: begin
                m_hready = ram_hreadyout;
                m_hresp  = ram_hresp;
                m_hrdata = ram_hrdata;
            end
            DP_UART: begin
                m_hready = uart_hreadyout;
                m_hresp  = uart_hresp;
                m_hrdata = uart_hrdata;
            end
            DP_DEF: begin
                m_hready = ds_hready;
                m_hresp  = ds_hresp;
            end
            default: begin
                m_hready = 1'b1;
            end
        endcase
    end

`ifdef TANG20K_DMEM_ERRLOG_EN
    logic        err_valid_q;
    logic [31:0] err_addr_q;
    logic        err_log;
    logic        unused_sig;

    // a clear in the same cycle frees the slot for the new error
    assign err_log = m_hready && m_hresp && (!err_valid_q || err_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'd0;
        end else if (err_log) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= daddr_q;
        end else if (err_clr) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'd0;
        end
    end

    assign err_valid  = err_valid_q;
    assign err_addr   = err_addr_q;
    assign unused_sig = m_hwrite;
`else
    logic [33:0] unused_sig;

    assign err_valid  = 1'b0;
    assign err_addr   = 32'd0;
    assign unused_sig = {m_hwrite, err_clr, daddr_q};
`endif

endmodule

// File: tb/tb_tang20k_dmem_decoder.sv
// Scoreboard bench for tang20k_dmem_decoder: directed plan then random traffic,
// expectations from a transfer-level model of the decoder and error log.
module tb_tang20k_dmem_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic        m_hready;
    logic [31:0] m_hrdata;
    logic        m_hresp;
    logic        ram_hsel;
    logic        uart_hsel;
    logic        s_hready;
    logic        ram_hreadyout;
    logic        uart_hreadyout;
    logic [31:0] ram_hrdata;
    logic [31:0] uart_hrdata;
    logic        ram_hresp;
    logic        uart_hresp;
    logic        err_clr;
    logic        err_valid;
    logic [31:0] err_addr;

    tang20k_dmem_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .m_haddr        (m_haddr),
        .m_htrans       (m_htrans),
        .m_hwrite       (m_hwrite),
        .m_hready       (m_hready),
        .m_hrdata       (m_hrdata),
        .m_hresp        (m_hresp),
        .ram_hsel       (ram_hsel),
        .uart_hsel      (uart_hsel),
        .s_hready       (s_hready),
        .ram_hreadyout  (ram_hreadyout),
        .uart_hreadyout (uart_hreadyout),
        .ram_hrdata     (ram_hrdata),
        .uart_hrdata    (uart_hrdata),
        .ram_hresp      (ram_hresp),
        .uart_hresp     (uart_hresp),
        .err_clr        (err_clr),
        .err_valid      (err_valid),
        .err_addr       (err_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        hr;
        logic        rsp;
        logic [31:0] rd;
        logic        rs;
        logic        us;
        logic        ev;
        logic [31:0] ea;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // model: what the current data phase belongs to and how long it has run
    int          pend_tgt = 0;
    logic [31:0] pend_addr = 32'd0;
    int          def_cycles = 0;
    logic        log_v = 1'b0;
    logic [31:0] log_a = 32'd0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("m_hready", {31'd0, m_hready}, {31'd0, e.hr});
            check("s_hready", {31'd0, s_hready}, {31'd0, e.hr});
            check("m_hresp", {31'd0, m_hresp}, {31'd0, e.rsp});
            check("m_hrdata", m_hrdata, e.rd);
            check("ram_hsel", {31'd0, ram_hsel}, {31'd0, e.rs});
            check("uart_hsel", {31'd0, uart_hsel}, {31'd0, e.us});
            check("err_valid", {31'd0, err_valid}, {31'd0, e.ev});
            check("err_addr", err_addr, e.ea);
        end
    end

    task automatic cyc(input logic r, input logic [1:0] tr,
                       input logic [31:0] a, input logic w,
                       input logic rrdy, input logic [31:0] rd,
                       input logic rrsp, input logic urdy,
                       input logic [31:0] ud, input logic ursp,
                       input logic clr);
        exp_t e;
        logic is_ram;
        logic is_uart;
        rst = r;
        m_htrans = tr;
        m_haddr = a;
        m_hwrite = w;
        ram_hreadyout = rrdy;
        ram_hrdata = rd;
        ram_hresp = rrsp;
        uart_hreadyout = urdy;
        uart_hrdata = ud;
        uart_hresp = ursp;
        err_clr = clr;
        is_ram = (a[31:16] == 16'h0000);
        is_uart = (a[31:16] == 16'hFFDF);
        e.rs = is_ram;
        e.us = is_uart;
        e.ev = log_v;
        e.ea = log_a;
        case (pend_tgt)
            1: begin e.hr = rrdy; e.rsp = rrsp; e.rd = rd; end
            2: begin e.hr = urdy; e.rsp = ursp; e.rd = ud; end
            3: begin e.hr = (def_cycles != 0); e.rsp = 1'b1; e.rd = 32'd0; end
            default: begin e.hr = 1'b1; e.rsp = 1'b0; e.rd = 32'd0; end
        endcase
        exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            pend_tgt = 0;
            pend_addr = 32'd0;
            def_cycles = 0;
            log_v = 1'b0;
            log_a = 32'd0;
        end else begin
`ifdef TANG20K_DMEM_ERRLOG_EN
            if (e.hr && e.rsp && (!log_v || clr)) begin
                log_v = 1'b1;
                log_a = pend_addr;
            end else if (clr) begin
                log_v = 1'b0;
                log_a = 32'd0;
            end
`endif
            if (e.hr) begin
                pend_tgt = !tr[1] ? 0 : is_ram ? 1 : is_uart ? 2 : 3;
                pend_addr = a;
                def_cycles = 0;
            end else if (pend_tgt == 3) begin
                def_cycles++;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] a, input logic clr);
        cyc(1'b0, 2'b00, a, 1'b0, 1'b1, 32'h0, 1'b0,
            1'b1, 32'h0, 1'b0, clr);
    endtask

    task automatic req(input logic [31:0] a, input logic w);
        cyc(1'b0, 2'b10, a, w, 1'b1, 32'h0, 1'b0,
            1'b1, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        m_haddr = 32'd0;
        m_htrans = 2'b00;
        m_hwrite = 1'b0;
        ram_hreadyout = 1'b1;
        uart_hreadyout = 1'b1;
        ram_hrdata = 32'd0;
        uart_hrdata = 32'd0;
        ram_hresp = 1'b0;
        uart_hresp = 1'b0;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 2'b00, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0,
            1'b1, 32'h0, 1'b0, 1'b0);
        idle(32'h0, 1'b0);

        // RAM read, zero waits
        req(32'h0000_0010, 1'b0);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0,
            1'b1, 32'h1111_2222, 1'b0, 1'b0);

        // UART write with three wait states; master address wanders
        req(32'hFFDF_0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'b10, 32'h8000_0000 + i, 1'b0, 1'b1, 32'h5, 1'b1,
                1'b0, 32'hCAFE_0000 + i, 1'b0, 1'b0);
        end
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 32'h5, 1'b0,
            1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);

        // single unmapped transfer
        req(32'h8000_0000, 1'b0);
        idle(32'h0, 1'b0);
        idle(32'h0, 1'b0);
        idle(32'h0, 1'b1);

        // back-to-back unmapped, then clear plus a third error together
        req(32'h9000_0000, 1'b0);
        req(32'hA000_0000, 1'b0);
        req(32'hA000_0000, 1'b0);
        idle(32'h0, 1'b0);
        req(32'hB000_0000, 1'b0);
        idle(32'h0, 1'b0);
        idle(32'h0, 1'b1);
        idle(32'h0, 1'b0);

        // reset during the first error cycle
        req(32'hC000_0000, 1'b0);
        cyc(1'b1, 2'b00, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0,
            1'b1, 32'h0, 1'b0, 1'b0);
        req(32'h0000_0020, 1'b0);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0,
            1'b1, 32'h0, 1'b0, 1'b0);

        // IDLE to unmapped address: OKAY, no log
        idle(32'h1234_5678, 1'b0);
        idle(32'h0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [1:0]  sel;
            sel = 2'($urandom_range(0, 2));
            a = $urandom;
            if (sel == 2'd0) a[31:16] = 16'h0000;
            else if (sel == 2'd1) a[31:16] = 16'hFFDF;
            cyc($urandom_range(0, 49) == 0, 2'($urandom), a, 1'($urandom),
                $urandom_range(0, 3) != 0, $urandom,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) != 0, $urandom,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 19) == 0);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
